// File: rtl/sequenciador_escalar.sv
// Multiplies a latched 5x5 signed 8-bit matrix by a signed 8-bit scalar,
// one column per cycle through five lane multipliers, with wrap and overflow flag.

module sequenciador_escalar_lane (
  input  logic signed [7:0] a,
  input  logic signed [7:0] b,
  output logic        [7:0] p,
  output logic              ovf
);
  logic signed [15:0] prod;

  assign prod = a * b;
  assign p    = prod[7:0];
  // product fits in 8 bits only when bits [15:7] are a pure sign extension
  assign ovf  = (prod[15:7] != {9{prod[15]}});
endmodule

module sequenciador_escalar (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                cancelar,
  input  logic signed [199:0] matriz_entrada,
  input  logic signed [7:0]   escalar,
  output logic        [199:0] matriz_saida,
  output logic                busy,
  output logic                done,
  output logic                overflow
);
  localparam int NUM_LANES = 5;
  localparam int VEC_W     = 8;

  typedef enum logic [1:0] {IDLE, CALC, FIM} state_t;

  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [NUM_LANES-1:0][NUM_LANES-1:0][VEC_W-1:0] mat_q, mat_d;
  logic [NUM_LANES-1:0][NUM_LANES-1:0][VEC_W-1:0] out_q, out_d;
  logic [VEC_W-1:0] esc_q, esc_d;
  logic             ovf_q, ovf_d;

  logic [NUM_LANES-1:0][VEC_W-1:0] lane_p;
  logic [NUM_LANES-1:0]            lane_ovf;

  // one lane per row of the column currently selected by the counter
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    sequenciador_escalar_lane u_lane (
      .a   (mat_q[cnt_q][g]),
      .b   (esc_q),
      .p   (lane_p[g]),
      .ovf (lane_ovf[g])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mat_d   = mat_q;
    esc_d   = esc_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    done    = 1'b0;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start && !cancelar) begin
          mat_d   = matriz_entrada;
          esc_d   = escalar;
          cnt_d   = 3'd0;
          ovf_d   = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cancelar) begin
          out_d   = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end else begin
          out_d[cnt_q] = lane_p;
          ovf_d        = ovf_q | (|lane_ovf);
          cnt_d        = cnt_q + 3'd1;
          if (cnt_q == 3'd4) state_d = FIM;
        end
      end
      FIM: begin
        state_d = IDLE;
        if (cancelar) begin
          out_d = '0;
          ovf_d = 1'b0;
        end else begin
          done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      mat_q   <= '0;
      esc_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mat_q   <= mat_d;
      esc_q   <= esc_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign matriz_saida = out_q;
  assign overflow     = ovf_q;
endmodule

// File: tb/tb_sequenciador_escalar.sv
// Directed bench for sequenciador_escalar: timing, wrap/overflow, cancel, reset, back-to-back.

module tb_sequenciador_escalar;
  logic         clk;
  logic         rst_n;
  logic         start;
  logic         cancelar;
  logic [199:0] matriz_entrada;
  logic [7:0]   escalar;
  logic [199:0] matriz_saida;
  logic         busy;
  logic         done;
  logic         overflow;

  int errors = 0;
  int checks = 0;

  sequenciador_escalar dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cancelar       (cancelar),
    .matriz_entrada (matriz_entrada),
    .escalar        (escalar),
    .matriz_saida   (matriz_saida),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [199:0] fill(input logic [7:0] v);
    return {25{v}};
  endfunction

  // element (c,l) = s*(c*5+l-12)
  function automatic logic [199:0] pat(input int s);
    logic [199:0] m;
    m = '0;
    for (int c = 0; c < 5; c++)
      for (int l = 0; l < 5; l++)
        m[8*(l+5*c) +: 8] = 8'(s * (c*5 + l - 12));
    return m;
  endfunction

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; cancelar = 1'b0;
    matriz_entrada = '0; escalar = '0;
    #1 rst_n = 1'b0;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    checks++; if (matriz_saida !== 200'd0) begin errors++; $display("FAIL reset_out: got %h want 0", matriz_saida); end
    @(negedge clk);
    matriz_entrada = fill(8'd3); escalar = 8'd2; start = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_held_busy: got %b want 0", busy); end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int nbusy, ndone, dpos;
    nbusy = 0; ndone = 0; dpos = 0;
    matriz_entrada = fill(8'd3); escalar = 8'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (busy === 1'b1) nbusy++;
      if (done === 1'b1) begin
        ndone++; dpos = k;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf_at_done: got %b want 0", overflow); end
      end
      @(negedge clk);
    end
    checks++; if (nbusy !== 6) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 6", nbusy); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", ndone); end
    checks++; if (dpos !== 6) begin errors++; $display("FAIL basic_done_pos: got %0d want 6", dpos); end
    checks++; if (matriz_saida !== fill(8'd6)) begin errors++; $display("FAIL basic_out: got %h want %h", matriz_saida, fill(8'd6)); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_wrap();
    logic [199:0] m, exp;
    int ndone;
    ndone = 0;
    m = fill(8'd1); m[7:0] = 8'd100;
    exp = fill(8'd2); exp[7:0] = 8'hC8;
    matriz_entrada = m; escalar = 8'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (done === 1'b1) begin
        ndone++;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL wrap_ovf_at_done: got %b want 1", overflow); end
      end
      @(negedge clk);
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL wrap_done_count: got %0d want 1", ndone); end
    checks++; if (matriz_saida !== exp) begin errors++; $display("FAIL wrap_out: got %h want %h", matriz_saida, exp); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL wrap_ovf_held: got %b want 1", overflow); end
  endtask

  task automatic test_negate();
    logic [199:0] old_v, new_v;
    logic [39:0]  ecol;
    int ndone;
    ndone = 0;
    old_v = fill(8'd2); old_v[7:0] = 8'hC8;
    new_v = pat(-1);
    matriz_entrada = pat(1); escalar = 8'hFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      for (int c = 0; c < 5; c++) begin
        ecol = (k >= c + 2) ? new_v[40*c +: 40] : old_v[40*c +: 40];
        checks++;
        if (matriz_saida[40*c +: 40] !== ecol) begin
          errors++; $display("FAIL negate_col%0d_sample%0d: got %h want %h", c, k, matriz_saida[40*c +: 40], ecol);
        end
      end
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL negate_done_count: got %0d want 1", ndone); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL negate_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_ignore_start();
    int ndone;
    ndone = 0;
    matriz_entrada = fill(8'd5); escalar = 8'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (done === 1'b1) ndone++;
      if (k == 2) begin matriz_entrada = fill(8'd7); escalar = 8'd4; start = 1'b1; end
      if (k == 4) start = 1'b0;
      @(negedge clk);
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
    checks++; if (matriz_saida !== fill(8'd15)) begin errors++; $display("FAIL ignore_out: got %h want %h", matriz_saida, fill(8'd15)); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ignore_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_cancel();
    int ndone;
    ndone = 0;
    matriz_entrada = fill(8'd3); escalar = 8'd2; start = 1'b1; cancelar = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_idle_busy: got %b want 0", busy); end
    checks++; if (matriz_saida !== fill(8'd15)) begin errors++; $display("FAIL cancel_idle_out: got %h want %h", matriz_saida, fill(8'd15)); end
    start = 1'b0; cancelar = 1'b0;
    matriz_entrada = fill(8'd100); escalar = 8'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      if (done === 1'b1) ndone++;
      if (k < 3) @(negedge clk);
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL cancel_partial_ovf: got %b want 1", overflow); end
    checks++; if (matriz_saida[7:0] !== 8'hC8) begin errors++; $display("FAIL cancel_partial_out: got %h want c8", matriz_saida[7:0]); end
    cancelar = 1'b1;
    @(negedge clk); cancelar = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b want 0", busy); end
    checks++; if (matriz_saida !== 200'd0) begin errors++; $display("FAIL cancel_out: got %h want 0", matriz_saida); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL cancel_ovf: got %b want 0", overflow); end
    for (int k = 0; k < 6; k++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL cancel_no_done: got %0d want 0", ndone); end
    matriz_entrada = fill(8'd3); escalar = 8'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL cancel_restart_done: got %0d want 1", ndone); end
    checks++; if (matriz_saida !== fill(8'd6)) begin errors++; $display("FAIL cancel_restart_out: got %h want %h", matriz_saida, fill(8'd6)); end
  endtask

  task automatic test_reset_mid();
    int ndone;
    ndone = 0;
    matriz_entrada = fill(8'd9); escalar = 8'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_ovf: got %b want 0", overflow); end
    checks++; if (matriz_saida !== 200'd0) begin errors++; $display("FAIL rstmid_out: got %h want 0", matriz_saida); end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (done === 1'b1 || busy === 1'b1) ndone++;
      @(negedge clk);
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL rstmid_no_activity: got %0d want 0", ndone); end
    matriz_entrada = pat(1); escalar = 8'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL rstmid_restart_done: got %0d want 1", ndone); end
    checks++; if (matriz_saida !== pat(1)) begin errors++; $display("FAIL rstmid_identity: got %h want %h", matriz_saida, pat(1)); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_ovf_after: got %b want 0", overflow); end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    d1 = 0; d2 = 0;
    matriz_entrada = fill(8'd1); escalar = 8'd4; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      if (done === 1'b1) begin
        if (d1 == 0) d1 = k; else d2 = k;
      end
      if (k == 7) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_gap_busy: got %b want 0", busy); end
        checks++; if (matriz_saida !== fill(8'd4)) begin errors++; $display("FAIL b2b_first_out: got %h want %h", matriz_saida, fill(8'd4)); end
        matriz_entrada = fill(8'd2); escalar = 8'hFD; start = 1'b1;
      end
      if (k == 8) start = 1'b0;
      @(negedge clk);
    end
    checks++; if (d1 !== 6) begin errors++; $display("FAIL b2b_first_done: got %0d want 6", d1); end
    checks++; if (d2 !== 13) begin errors++; $display("FAIL b2b_second_done: got %0d want 13", d2); end
    checks++; if (matriz_saida !== fill(8'hFA)) begin errors++; $display("FAIL b2b_second_out: got %h want %h", matriz_saida, fill(8'hFA)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_negate();
    test_ignore_start();
    test_cancel();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sequenciador_escalar.md
SEQUENCIADOR_ESCALAR -- requirements
Module: sequenciador_escalar

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL have port start, input, 1 bit: request to multiply the presented matrix by the presented scalar.
REQ-004 SHALL have port cancelar, input, 1 bit: synchronous abort of the operation in progress.
REQ-005 SHALL have port matriz_entrada, input, 200 bits, signed: 5x5 matrix, 8-bit elements; element (coluna, linha) occupies bits 8*(linha+5*coluna) +: 8.
REQ-006 SHALL have port escalar, input, 8 bits, signed: scalar multiplier.
REQ-007 SHALL have port matriz_saida, output, 200 bits, registered: result matrix, same element layout as matriz_entrada.
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is accepted and not yet finished.
REQ-009 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-010 SHALL have port overflow, output, 1 bit: at least one product did not fit in signed 8 bits; valid while done=1 and held afterwards.

Function
REQ-011 SHALL implement FSM states IDLE, CALC and FIM.
REQ-012 SHALL, in IDLE with start=1 and cancelar=0, latch matriz_entrada and escalar, clear the 3-bit column counter and overflow accumulator, and move to CALC.
REQ-013 SHALL ignore start in CALC and FIM; latched operands SHALL NOT change until the next accepted start.
REQ-014 SHALL, in CALC, process one column per cycle (5 elements, bits 40*coluna +: 40) in the order coluna = 0,1,2,3,4, using exactly 5 signed 8x8 multipliers.
REQ-015 SHALL take each element result as bits [7:0] of the full 16-bit signed product (two's-complement wrap, no saturation).
REQ-016 SHALL set the overflow accumulator if any 16-bit product lies outside -128..127.
REQ-017 SHALL go from CALC to FIM after the column-4 write; an operation accepted at edge N SHALL write columns at edges N+1..N+5 and enter FIM at edge N+5.
REQ-018 SHALL, in FIM, assert done=1 for exactly one cycle, with overflow showing the final accumulator value, then return to IDLE.
REQ-019 SHALL drive busy=1 in CALC and FIM and busy=0 in IDLE.
REQ-020 SHALL hold matriz_saida and overflow from FIM until the next accepted start; columns not yet written in a new operation SHALL keep their previous values.
REQ-021 SHALL, on cancelar=1 in CALC or FIM, return to IDLE on that edge, set matriz_saida=0 and overflow=0, and not assert done.
REQ-022 SHALL treat cancelar=1 in IDLE as taking priority over start: no operation is accepted.
REQ-023 SHALL accept a start presented in the cycle after done, giving back-to-back operations every 7 cycles.

Reset
REQ-024 SHALL, while rst_n=0 and independent of clk, force state=IDLE, column counter=0, latched operands=0, matriz_saida=0, busy=0, done=0 and overflow=0.
REQ-025 SHALL, on reset asserted mid-operation, abandon the operation with no done pulse; the first start after rst_n deasserts SHALL be accepted normally.

Verification
REQ-026 SHALL verify: all elements=3, escalar=2, start pulse -> busy high 6 cycles, done at cycle 6, all elements=6, overflow=0.
REQ-027 SHALL verify: element (0,0)=100, others=1, escalar=2 -> element (0,0)=0xC8 (wrap), others=2, overflow=1.
REQ-028 SHALL verify: element (c,l)=c*5+l-12, escalar=-1 -> every element negated, overflow=0; column c result appears exactly at edge N+1+c.
REQ-029 SHALL verify: start again while busy with different operands -> ignored, result matches the first operands, one done only.
REQ-030 SHALL verify: cancelar at the third CALC cycle -> busy=0 next cycle, matriz_saida=0, no done; a following start completes normally.
REQ-031 SHALL verify: rst_n pulled low between clock edges in CALC -> outputs 0 immediately; after release, start with escalar=1 -> output equals input.
